// File: rtl/pipe_select_stage.sv
// pipe_select_stage: registered N-to-1 select stage with bubble insertion,
// valid/ready flow control and a two-entry skid buffer (main + skid).
// Optional feature macro: PIPE_SELECT_BUBBLE_CNT_EN adds bubble_count_o,
// a saturating count of accepted bubble beats.

module pipe_select_stage #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_IN*WIDTH-1:0] in_data_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic                    bubble_i,
   input  logic                    flush_i,
   output logic [WIDTH-1:0]        out_data_o,
   output logic                    out_valid_o,
   output logic                    out_bubble_o,
   input  logic                    out_ready_i
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
   ,
   output logic [15:0]             bubble_count_o
`endif
);

   // Every select code gets a slot; codes beyond NUM_IN read as zero so an
   // out-of-range select stores a zero payload without a range comparison.
   localparam int NUM_SLOTS = 1 << SEL_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   mainData_q, mainData_d;
   logic               mainBubble_q, mainBubble_d;
   logic [WIDTH-1:0]   skidData_q, skidData_d;
   logic               skidBubble_q, skidBubble_d;

   logic [WIDTH-1:0]   chanSlot [NUM_SLOTS];
   logic [WIDTH-1:0]   newData;
   logic               newBubble;
   logic               accept;
   logic               pop;

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      if (k < NUM_IN) begin : g_real
         assign chanSlot[k] = in_data_i[k*WIDTH +: WIDTH];
      end else begin : g_zero
         assign chanSlot[k] = '0;
      end
   end

   // in_ready depends only on registered state and reset, never on out_ready.
   assign in_ready_o   = rst_ni & (state_q != FULL);
   assign out_valid_o  = (state_q != EMPTY);
   assign out_data_o   = out_valid_o ? mainData_q : '0;
   assign out_bubble_o = out_valid_o & mainBubble_q;

   assign accept = in_valid_i & in_ready_o;
   assign pop    = out_valid_o & out_ready_i;

   // Payload captured for an accepted beat: a bubble overrides the selected channel with zero.
   always_comb begin
      newData   = chanSlot[sel_i];
      newBubble = 1'b0;
      if (bubble_i) begin
         newData   = '0;
         newBubble = 1'b1;
      end
   end

   // Next-state and entry movement; flush empties the stage and drops the offered beat.
   always_comb begin
      state_d      = state_q;
      mainData_d   = mainData_q;
      mainBubble_d = mainBubble_q;
      skidData_d   = skidData_q;
      skidBubble_d = skidBubble_q;
      if (flush_i) begin
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  mainData_d   = newData;
                  mainBubble_d = newBubble;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  mainData_d   = newData;
                  mainBubble_d = newBubble;
               end else if (accept) begin
                  skidData_d   = newData;
                  skidBubble_d = newBubble;
                  state_d      = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  mainData_d   = skidData_q;
                  mainBubble_d = skidBubble_q;
                  state_d      = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State and entry registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= EMPTY;
         mainData_q   <= '0;
         mainBubble_q <= 1'b0;
         skidData_q   <= '0;
         skidBubble_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mainData_q   <= mainData_d;
         mainBubble_q <= mainBubble_d;
         skidData_q   <= skidData_d;
         skidBubble_q <= skidBubble_d;
      end
   end

`ifdef PIPE_SELECT_BUBBLE_CNT_EN
   logic [15:0] bubbleCnt_q, bubbleCnt_d;

   // Count bubble beats that are actually stored; saturates, cleared only by reset.
   always_comb begin
      bubbleCnt_d = bubbleCnt_q;
      if (accept && bubble_i && !flush_i && (bubbleCnt_q != 16'hFFFF)) begin
         bubbleCnt_d = bubbleCnt_q + 16'd1;
      end
   end

   // Bubble counter register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bubbleCnt_q <= '0;
      end else begin
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign bubble_count_o = bubbleCnt_q;
`endif

endmodule

// File: tb/tb_pipe_select_stage.sv
// Testbench for pipe_select_stage: a 4-input and a 3-input instance share the
// same stimulus; a queue model predicts both every cycle, and directed
// literal checks pin the model at the interesting points.

module tb_pipe_select_stage;

   logic         clk;
   logic         rstN;
   logic [127:0] inData;
   logic [1:0]   sel;
   logic         inValid;
   logic         bubble;
   logic         flush;
   logic         outReady;

   logic         inReady4, outValid4, outBubble4;
   logic [31:0]  outData4;
   logic         inReady3, outValid3, outBubble3;
   logic [31:0]  outData3;

   int vectorCount = 0;
   int missCount   = 0;
   bit armed       = 0;

   typedef struct {
      logic [31:0] data;
      logic        bub;
   } entry_t;

   entry_t q4[$];
   entry_t q3[$];

`ifdef PIPE_SELECT_BUBBLE_CNT_EN
   logic [15:0] bubbleCount4, bubbleCount3;
   int          modelCnt = 0;
`endif

   pipe_select_stage #(.WIDTH(32), .NUM_IN(4)) dut4 (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .in_data_i    (inData),
      .sel_i        (sel),
      .in_valid_i   (inValid),
      .in_ready_o   (inReady4),
      .bubble_i     (bubble),
      .flush_i      (flush),
      .out_data_o   (outData4),
      .out_valid_o  (outValid4),
      .out_bubble_o (outBubble4),
      .out_ready_i  (outReady)
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
      ,
      .bubble_count_o (bubbleCount4)
`endif
   );

   pipe_select_stage #(.WIDTH(32), .NUM_IN(3)) dut3 (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .in_data_i    (inData[95:0]),
      .sel_i        (sel),
      .in_valid_i   (inValid),
      .in_ready_o   (inReady3),
      .bubble_i     (bubble),
      .flush_i      (flush),
      .out_data_o   (outData3),
      .out_valid_o  (outValid3),
      .out_bubble_o (outBubble3),
      .out_ready_i  (outReady)
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
      ,
      .bubble_count_o (bubbleCount3)
`endif
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic entry_t modelSelect(int numIn, logic [1:0] s, logic b, logic [127:0] d);
      entry_t e;
      e.data = 32'h0;
      e.bub  = 1'b0;
      if (b) begin
         e.bub = 1'b1;
      end else if (int'(s) < numIn) begin
         e.data = d[int'(s)*32 +: 32];
      end
      return e;
   endfunction

   task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectorCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two entries updated from the inputs seen at each edge.
   always @(posedge clk) begin
      automatic bit doPop;
      automatic bit doAcc;
      if (!rstN) begin
         q4.delete();
         q3.delete();
         armed = 1;
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
         modelCnt = 0;
`endif
      end else if (flush) begin
         q4.delete();
         q3.delete();
      end else begin
         doPop = (q4.size() > 0) && outReady;
         doAcc = inValid && (q4.size() < 2);
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
         if (doAcc && bubble && modelCnt < 65535) modelCnt++;
`endif
         if (doPop) begin
            void'(q4.pop_front());
            void'(q3.pop_front());
         end
         if (doAcc) begin
            q4.push_back(modelSelect(4, sel, bubble, inData));
            q3.push_back(modelSelect(3, sel, bubble, inData));
         end
      end
   end

   // Every mid-cycle, compare both instances against the model.
   always @(negedge clk) begin
      if (armed) begin
         compareVal("m4_valid",  {31'b0, outValid4},  {31'b0, q4.size() > 0});
         compareVal("m4_data",   outData4,  (q4.size() > 0) ? q4[0].data : 32'h0);
         compareVal("m4_bubble", {31'b0, outBubble4}, {31'b0, (q4.size() > 0) ? q4[0].bub : 1'b0});
         compareVal("m4_ready",  {31'b0, inReady4},   {31'b0, rstN && (q4.size() < 2)});
         compareVal("m3_valid",  {31'b0, outValid3},  {31'b0, q3.size() > 0});
         compareVal("m3_data",   outData3,  (q3.size() > 0) ? q3[0].data : 32'h0);
         compareVal("m3_bubble", {31'b0, outBubble3}, {31'b0, (q3.size() > 0) ? q3[0].bub : 1'b0});
         compareVal("m3_ready",  {31'b0, inReady3},   {31'b0, rstN && (q3.size() < 2)});
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
         compareVal("m4_bcount", {16'b0, bubbleCount4}, modelCnt[31:0]);
         compareVal("m3_bcount", {16'b0, bubbleCount3}, modelCnt[31:0]);
`endif
      end
   end

   task automatic setChan(input int k, input logic [31:0] val);
      inData[k*32 +: 32] = val;
   endtask

   task automatic applyStimulus(input logic r, input logic iv, input logic [1:0] s,
                                input logic b, input logic f, input logic ordy);
      rstN     = r;
      inValid  = iv;
      sel      = s;
      bubble   = b;
      flush    = f;
      outReady = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expData,
                              input logic expBubble, input logic expReady);
      compareVal({name, "_valid"},  {31'b0, outValid4},  {31'b0, expValid});
      compareVal({name, "_data"},   outData4, expData);
      compareVal({name, "_bubble"}, {31'b0, outBubble4}, {31'b0, expBubble});
      compareVal({name, "_ready"},  {31'b0, inReady4},   {31'b0, expReady});
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      rstN = 1'b0; inData = '0; sel = '0; inValid = 0; bubble = 0; flush = 0; outReady = 0;

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("in_reset", 0, 32'h0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("after_reset", 0, 32'h0, 0, 1);

      setChan(2, 32'hA5A5_0002);
      applyStimulus(1, 1, 2, 0, 0, 1);
      checkOutput("first_beat", 1, 32'hA5A5_0002, 0, 1);

      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) setChan(k, 32'h1000_0000 + i*16 + k);
         applyStimulus(1, 1, 2'(i % 4), 0, 0, 1);
         checkOutput($sformatf("stream%0d", i), 1, 32'h1000_0000 + i*16 + (i % 4), 0, 1);
      end
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("stream_drain", 0, 32'h0, 0, 1);

      setChan(0, 32'hAAAA_0001);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("stall_x", 1, 32'hAAAA_0001, 0, 1);
      setChan(1, 32'hBBBB_0002);
      applyStimulus(1, 1, 1, 0, 0, 0);
      checkOutput("stall_full", 1, 32'hAAAA_0001, 0, 0);
      setChan(2, 32'hCCCC_0003);
      applyStimulus(1, 1, 2, 0, 0, 0);
      checkOutput("stall_hold", 1, 32'hAAAA_0001, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("stall_y", 1, 32'hBBBB_0002, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("stall_drain", 0, 32'h0, 0, 1);

      setChan(1, 32'hDEAD_BEEF);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 1, 1, 0, 1);
         checkOutput($sformatf("bubble%0d", i), 1, 32'h0, 1, 1);
      end
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("bubble_drain", 0, 32'h0, 0, 1);
`ifdef PIPE_SELECT_BUBBLE_CNT_EN
      compareVal("bubble_count3", {16'b0, bubbleCount4}, 32'd3);
`endif

      setChan(0, 32'h1111_0001);
      applyStimulus(1, 1, 0, 0, 0, 0);
      setChan(0, 32'h2222_0002);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("flush_full", 1, 32'h1111_0001, 0, 0);
      setChan(0, 32'h3333_0003);
      applyStimulus(1, 1, 0, 0, 1, 1);
      checkOutput("flush_now", 0, 32'h0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("flush_after", 0, 32'h0, 0, 1);
      setChan(0, 32'h4444_0004);
      applyStimulus(1, 1, 0, 0, 0, 0);
      setChan(0, 32'h5555_0005);
      applyStimulus(1, 1, 0, 0, 1, 0);
      checkOutput("flush_one", 0, 32'h0, 0, 1);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("flush_one_after", 0, 32'h0, 0, 1);

      setChan(3, 32'h7777_0003);
      applyStimulus(1, 1, 3, 0, 0, 1);
      checkOutput("sel3_n4", 1, 32'h7777_0003, 0, 1);
      compareVal("oor_n3_valid",  {31'b0, outValid3},  32'd1);
      compareVal("oor_n3_data",   outData3, 32'h0);
      compareVal("oor_n3_bubble", {31'b0, outBubble3}, 32'd0);
      applyStimulus(1, 0, 0, 0, 0, 1);

      setChan(0, 32'h8888_0001);
      applyStimulus(1, 1, 0, 0, 0, 0);
      setChan(0, 32'h9999_0002);
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("rst_full", 1, 32'h8888_0001, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("rst_mid", 0, 32'h0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 1);
      checkOutput("rst_release", 0, 32'h0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/pipe_select_stage.md
Name: pipe_select_stage

Overview:
- Parametrised registered N-to-1 select stage with bubble insertion and valid/ready flow control. Successor to the combinational 2:1/4:1 and control-unit bubble muxes.
- Sits between pipeline stages, e.g. operand-forwarding selection into ID/EX or control-word zeroing on hazards.
- Holds a 2-entry skid buffer, so stalls (out_ready low) never lose data and in_ready is a registered signal.

Parameters:
- WIDTH, 32, payload width in bits.
- NUM_IN, 4, number of input channels (≥2).
- SEL_W, $clog2(NUM_IN), select width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel select, sampled with the input beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- bubble  in  1  when the beat is accepted, store an all-zero payload (NOP) instead of the selected channel.
- flush  in  1  discard all held entries.
- out_data  out  WIDTH  head payload.
- out_valid  out  1  head valid.
- out_bubble  out  1  head entry was inserted as a bubble.
- out_ready  in  1  downstream accepts the head.

Behaviour:
- Reset:
  - Synchronous, active-low, single clock, as decided.
  - While rst_n=0 at a rising edge: main and skid entries are invalidated.
  - out_valid=0, out_data=0, out_bubble=0; in_ready=0 while rst_n is low.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid and payload may change freely when in_ready=0. No combinational path from out_ready to in_ready.
- Selection, evaluated at the accept edge:
  - bubble=1 -> payload 0, bubble flag 1.
  - Otherwise, sel<NUM_IN -> channel sel, flag 0.
  - Otherwise (sel out of range) -> payload 0, flag 0.
- in_ready = rst_n & !skid_valid.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - FULL: main and skid valid.
- Transitions (no flush):
  - EMPTY + accept -> ONE. Entry shows on out_* the next cycle (latency 1).
  - ONE + accept + pop -> ONE, with main replaced by the new beat.
  - ONE + accept + !pop -> FULL, with the new beat in skid.
  - ONE + pop + !accept -> EMPTY.
  - FULL + pop -> ONE, with skid moving into main. No accept is possible in FULL because in_ready=0.
  - All other cases hold state.
- Ordering is strictly FIFO; out_data and out_bubble remain stable while out_valid=1 and out_ready=0.
- out_data is 0 whenever out_valid=0.
- flush:
  - Has priority over accept and pop in the same cycle; the input beat offered that cycle is dropped.
  - Next cycle: EMPTY, out_valid=0, in_ready=1.
- Reset mid-transfer drops both entries with no output glitch beyond the deassertion of out_valid.

Optional Feature:
- Macro PIPE_SELECT_BUBBLE_CNT_EN.
- Defined: adds output bubble_count [15:0].
  - Increments by 1 on each accepted beat with bubble=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset and first beat: rst_n=0 for 2 cycles, then release.
  - Expect out_valid=0, out_data=0, in_ready=1.
  - Then sel=2, ch2=32'hA5A5_0002, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_data=32'hA5A5_0002, out_bubble=0.
- Back-to-back streaming: 8 beats with sel cycling 0..3, out_ready=1 throughout.
  - One beat per cycle, latency 1, in_ready never drops, order preserved.
- Stall/skid: out_ready=0 while beats X then Y are offered.
  - After Y is accepted, in_ready=0 and out_data=X holds.
  - Raise out_ready -> X, then Y, on consecutive cycles; in_ready returns to 1 after X pops.
- Bubble: bubble=1, sel=1 with ch1=32'hDEAD_BEEF.
  - Expect out_data=0, out_bubble=1.
  - With PIPE_SELECT_BUBBLE_CNT_EN, after 3 bubbles bubble_count=3.
- Flush priority: hold FULL (out_ready=0), then assert flush together with in_valid=1 and out_ready=1.
  - Next cycle out_valid=0, in_ready=1; the dropped beat never appears.
- Out-of-range sel and mid-operation reset:
  - With NUM_IN=3, sel=3 -> out_data=0, out_bubble=0.
  - Reset while FULL -> out_valid=0 next cycle.
